// File: rtl/fir_sequencer_if.sv
// Sample-in / result-out stream bundle between the stream source/sink and fir_sequencer.
// slave = sequencer side, master = source/sink side.
interface fir_sequencer_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_bits;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_bits;

   modport slave (
      input  in_valid, in_bits, out_ready,
      output in_ready, out_valid, out_bits
   );

   modport master (
      output in_valid, in_bits, out_ready,
      input  in_ready, out_valid, out_bits
   );
endinterface

// File: rtl/fir_sequencer.sv
// Front-end controller for a 4-tap Fir: sample issue, result FIFO, double-buffered coefficients, tap flush.
// Optional FIR_SEQ_STATS_EN adds io_stat_samples_o, a wrapping count of accepted samples.
//
// state   | meaning
// S_RUN   | accepting samples; leaves for FLUSH on flush request, else SWAP when a commit is pending
// S_FLUSH | issuing FLUSH_LEN zero samples to the Fir, results discarded
// S_SWAP  | one cycle: active bank <= shadow bank (same-cycle write included)
module fir_sequencer #(
   parameter int W         = 4,
   parameter int OUT_DEPTH = 2,
   parameter int FLUSH_LEN = 3
) (
   input  logic          clock,
   input  logic          reset,
   fir_sequencer_if.slave strm,
   input  logic          io_cfg_wen_i,
   input  logic [1:0]    io_cfg_addr_i,
   input  logic [W-1:0]  io_cfg_data_i,
   input  logic          io_cfg_commit_i,
   input  logic          io_flush_i,
   output logic          io_busy_o,
   output logic [W-1:0]  fir_in_o,
   output logic          fir_valid_o,
   output logic [W-1:0]  fir_consts_0_o,
   output logic [W-1:0]  fir_consts_1_o,
   output logic [W-1:0]  fir_consts_2_o,
   output logic [W-1:0]  fir_consts_3_o,
   input  logic [W-1:0]  fir_out_i
`ifdef FIR_SEQ_STATS_EN
   ,
   output logic [15:0]   io_stat_samples_o
`endif
);

   localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW  = $clog2(OUT_DEPTH + 1);
   localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_SWAP} state_t;

   state_t         state_q;
   logic           pending_q;
   logic [FCW-1:0] flush_cnt_q;
   logic [W-1:0]   shadow_q [4];
   logic [W-1:0]   shadow_d [4];
   logic [W-1:0]   active_q [4];
   logic [W-1:0]   mem_q [OUT_DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;

   logic in_ready;
   logic accept;
   logic pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready = (state_q == S_RUN) && !pending_q && (count_q < CW'(OUT_DEPTH));
   assign accept   = in_ready && strm.in_valid;
   assign pop      = (count_q != '0) && strm.out_ready;

   assign strm.in_ready  = in_ready;
   assign strm.out_valid = (count_q != '0);
   assign strm.out_bits  = mem_q[rd_ptr_q];

   // Accepted samples go straight to the Fir; flush cycles feed zeros with valid high.
   assign fir_valid_o = accept || (state_q == S_FLUSH);
   assign fir_in_o    = accept ? strm.in_bits : '0;

   assign fir_consts_0_o = active_q[0];
   assign fir_consts_1_o = active_q[1];
   assign fir_consts_2_o = active_q[2];
   assign fir_consts_3_o = active_q[3];

   assign io_busy_o = (state_q != S_RUN) || pending_q || (count_q != '0);

   always_comb begin
      shadow_d = shadow_q;
      if (io_cfg_wen_i) shadow_d[io_cfg_addr_i] = io_cfg_data_i;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_RUN;
         pending_q   <= 1'b0;
         flush_cnt_q <= '0;
         shadow_q    <= '{default: '0};
         active_q    <= '{default: '0};
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         shadow_q <= shadow_d;

         // A commit arriving during SWAP re-arms pending for another copy.
         if (io_cfg_commit_i)        pending_q <= 1'b1;
         else if (state_q == S_SWAP) pending_q <= 1'b0;

         case (state_q)
            S_RUN: begin
               if (io_flush_i) begin
                  state_q     <= S_FLUSH;
                  flush_cnt_q <= FCW'(FLUSH_LEN - 1);
               end else if (pending_q) begin
                  state_q <= S_SWAP;
               end
            end
            S_FLUSH: begin
               if (flush_cnt_q == '0) state_q <= S_RUN;
               else                   flush_cnt_q <= flush_cnt_q - FCW'(1);
            end
            S_SWAP: begin
               active_q <= shadow_d;
               state_q  <= S_RUN;
            end
            default: state_q <= S_RUN;
         endcase

         if (accept) begin
            mem_q[wr_ptr_q] <= fir_out_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

         case ({accept, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef FIR_SEQ_STATS_EN
   logic [15:0] stat_q;

   always_ff @(posedge clock) begin
      if (reset)       stat_q <= '0;
      else if (accept) stat_q <= stat_q + 16'd1;
   end

   assign io_stat_samples_o = stat_q;
`endif

endmodule
